// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
// Build option: UART_PARSER_TIMEOUT_EN enables the inter-byte gap timeout.
package uart_frame_pkg;

  // Start-of-frame marker.
  localparam logic [7:0] SOF = 8'hA5;

  // Parser states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_OUT
  } state_t;

  // Cause reported with a dropped frame.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  // States in which the parser is collecting bytes of a started frame.
  function automatic logic in_frame(state_t s);
    return (s == S_LEN) || (s == S_PAYLOAD) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: register array, synchronous write, asynchronous read.
// Build option: none (UART_PARSER_TIMEOUT_EN only affects the top).
module uart_frame_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one payload byte per write strobe.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser: pops bytes from the receive FIFO, hunts for SOF,
// collects a length-prefixed payload, verifies the additive checksum and
// streams verified payloads out on a valid/ready port with a last marker.
// Build option: define UART_PARSER_TIMEOUT_EN to drop frames whose
// inter-byte gap reaches TIMEOUT cycles (err_code 3).
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_avail,
  output logic             rx_rd_en,
  input  logic [WIDTH-1:0] rx_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [7:0]       err_cnt
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // One extra bit so a MAX_LEN of 256 compares correctly against a byte.
  localparam logic [WIDTH:0] MAX_LEN_W = (WIDTH+1)'(MAX_LEN);

  state_t           state_reg, state_next;
  logic             rd_en_reg, rd_en_next;
  logic             pend_reg;               // read data arrives this cycle
  logic [AW-1:0]    last_reg, last_next;    // index of final payload byte
  logic [AW-1:0]    idx_reg, idx_next;      // payload write index
  logic [AW-1:0]    rd_idx_reg, rd_idx_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             m_valid_reg, m_valid_next;
  logic             frame_ok_reg, frame_ok_next;
  logic             frame_err_reg, frame_err_next;
  err_t             err_code_reg, err_code_next;
  logic [7:0]       err_cnt_reg, err_cnt_next;
  logic             buf_we;
  logic [WIDTH-1:0] buf_rd_data;
  logic             err_fire;
  err_t             err_cause;
  logic             timeout_hit;

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT + 1);
  logic [GW-1:0] gap_reg;

  // Gap counter: cleared by each captured byte, runs only inside a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_reg <= '0;
    end else if (pend_reg || !in_frame(state_reg)) begin
      gap_reg <= '0;
    end else begin
      gap_reg <= gap_reg + 1'b1;
    end
  end

  assign timeout_hit = in_frame(state_reg) && !pend_reg &&
                       (gap_reg == GW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  uart_frame_buf #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (idx_reg),
    .wr_data (rx_data),
    .rd_addr (rd_idx_reg),
    .rd_data (buf_rd_data)
  );

  // Next-state, datapath and FIFO read decisions.
  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    idx_next       = idx_reg;
    rd_idx_next    = rd_idx_reg;
    sum_next       = sum_reg;
    m_valid_next   = m_valid_reg;
    frame_ok_next  = 1'b0;
    frame_err_next = 1'b0;
    err_code_next  = err_code_reg;
    err_cnt_next   = err_cnt_reg;
    buf_we         = 1'b0;
    err_fire       = 1'b0;
    err_cause      = ERR_NONE;

    case (state_reg)
      S_IDLE: begin
        // Non-SOF bytes are dropped silently while hunting.
        if (pend_reg && (rx_data == WIDTH'(SOF))) begin
          state_next = S_LEN;
        end
      end
      S_LEN: begin
        if (pend_reg) begin
          if ((rx_data == '0) || ({1'b0, rx_data} > MAX_LEN_W)) begin
            err_fire  = 1'b1;
            err_cause = ERR_LEN;
          end else begin
            last_next  = AW'(rx_data - 1'b1);
            sum_next   = rx_data;
            idx_next   = '0;
            state_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        // SOF values inside the payload are ordinary data.
        if (pend_reg) begin
          buf_we   = 1'b1;
          sum_next = sum_reg + rx_data;
          idx_next = idx_reg + 1'b1;
          if (idx_reg == last_reg) begin
            state_next = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (pend_reg) begin
          if (rx_data == sum_reg) begin
            frame_ok_next = 1'b1;
            m_valid_next  = 1'b1;
            rd_idx_next   = '0;
            state_next    = S_OUT;
          end else begin
            err_fire  = 1'b1;
            err_cause = ERR_CSUM;
          end
        end
      end
      S_OUT: begin
        if (m_valid_reg && m_ready) begin
          if (rd_idx_reg == last_reg) begin
            m_valid_next = 1'b0;
            state_next   = S_IDLE;
          end else begin
            rd_idx_next = rd_idx_reg + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A timeout can only fire on a cycle with no capture, so it never
    // competes with a byte-driven transition above.
    if (timeout_hit) begin
      err_fire  = 1'b1;
      err_cause = ERR_TIMEOUT;
    end

    if (err_fire) begin
      state_next     = S_IDLE;
      frame_err_next = 1'b1;
      err_code_next  = err_cause;
      if (err_cnt_reg != 8'hFF) begin
        err_cnt_next = err_cnt_reg + 1'b1;
      end
    end

    // One read in flight at a time; decided from the next state so a read
    // may issue on the cycle right after the last beat leaves.
    rd_en_next = rx_avail && !rd_en_reg && (state_next != S_OUT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      rd_en_reg     <= 1'b0;
      pend_reg      <= 1'b0;
      last_reg      <= '0;
      idx_reg       <= '0;
      rd_idx_reg    <= '0;
      sum_reg       <= '0;
      m_valid_reg   <= 1'b0;
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      err_code_reg  <= ERR_NONE;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      rd_en_reg     <= rd_en_next;
      pend_reg      <= rd_en_reg;
      last_reg      <= last_next;
      idx_reg       <= idx_next;
      rd_idx_reg    <= rd_idx_next;
      sum_reg       <= sum_next;
      m_valid_reg   <= m_valid_next;
      frame_ok_reg  <= frame_ok_next;
      frame_err_reg <= frame_err_next;
      err_code_reg  <= err_code_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign rx_rd_en  = rd_en_reg;
  assign m_valid   = m_valid_reg;
  // Gated by m_valid so the stream reads as zero outside OUT and after reset.
  assign m_data    = m_valid_reg ? buf_rd_data : '0;
  assign m_last    = m_valid_reg && (rd_idx_reg == last_reg);
  assign frame_ok  = frame_ok_reg;
  assign frame_err = frame_err_reg;
  assign err_code  = err_code_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: FIFO model, random and directed
// byte streams, and a frame-level reference parser of the byte stream.
// Build option: UART_PARSER_TIMEOUT_EN adds a gap-timeout scenario.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 64;

  logic       clk;
  logic       rst;
  logic       rx_avail;
  logic       rx_rd_en;
  logic [7:0] rx_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;

  uart_frame_parser #(
    .WIDTH   (8),
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_avail  (rx_avail),
    .rx_rd_en  (rx_rd_en),
    .rx_data   (rx_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total = 0;
  int checks_pass  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Bytes waiting in the receive FIFO.
  logic [7:0] fifo_q[$];
  // Stream under construction before it is modelled and queued.
  logic [7:0] stream_q[$];
  // Expected frame events in order: 0 = verified frame, 1..3 = error code.
  int         ev_kind[$];
  int         ev_len[$];
  logic [7:0] ev_bytes[$];
  // Payload of the frame currently being streamed out.
  logic [7:0] cur_pl[$];
  int         model_err_cnt = 0;
  int         ready_mode = 0;   // 0 always ready, 1 random, 2 toggle
  int         gate_mode  = 0;   // 0 FIFO avail whenever non-empty, 1 random gaps

  // Reference: parse the stream frame by frame and queue expected events.
  task automatic model_and_send();
    int i = 0;
    int n = stream_q.size();
    while (i < n) begin
      int l;
      int sum;
      if (stream_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= n) break;
      l = int'(stream_q[i+1]);
      if (l == 0 || l > MAX_LEN) begin
        ev_kind.push_back(1);
        i += 2;
        continue;
      end
      if (i + 2 + l >= n) break;
      sum = l;
      for (int k = 0; k < l; k++) sum += int'(stream_q[i+2+k]);
      if (int'(stream_q[i+2+l]) == (sum % 256)) begin
        ev_kind.push_back(0);
        ev_len.push_back(l);
        for (int k = 0; k < l; k++) ev_bytes.push_back(stream_q[i+2+k]);
      end else begin
        ev_kind.push_back(2);
      end
      i += 3 + l;
    end
    foreach (stream_q[j]) fifo_q.push_back(stream_q[j]);
    $display("stream queued: %0d bytes, %0d events pending", n, ev_kind.size());
  endtask

  // Per-cycle FIFO model, event/beat monitor and consumer driver.
  initial begin
    logic       prev_rd = 1'b0;
    logic       last_xfer = 1'b0;
    logic       have_hold = 1'b0;
    logic [7:0] hold_data = '0;
    logic       hold_last = 1'b0;
    rx_avail = 1'b0;
    rx_data  = '0;
    m_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_avail  = 1'b0;
        prev_rd   = 1'b0;
        last_xfer = 1'b0;
        have_hold = 1'b0;
      end else begin
        if (rx_rd_en) begin
          check_eq("rd_needs_avail", int'(rx_avail), 1);
          check_eq("rd_back_to_back", int'(prev_rd), 0);
          check_eq("rd_during_out", int'(m_valid), 0);
          if (fifo_q.size() != 0) rx_data = fifo_q.pop_front();
        end
        prev_rd = rx_rd_en;

        if (last_xfer) check_eq("valid_after_last", int'(m_valid), 0);
        last_xfer = 1'b0;

        if (frame_ok || frame_err) begin
          int got_kind;
          got_kind = (frame_ok && frame_err) ? 4 : (frame_ok ? 0 : int'(err_code));
          if (ev_kind.size() == 0) begin
            check_eq("unexpected_pulse", got_kind + 10, 0);
          end else begin
            int k;
            k = ev_kind.pop_front();
            check_eq("event_kind", got_kind, k);
            if (k == 0) begin
              int l;
              l = ev_len.pop_front();
              for (int b = 0; b < l; b++) begin
                logic [7:0] v;
                v = ev_bytes.pop_front();
                if (frame_ok) cur_pl.push_back(v);
              end
            end else begin
              if (model_err_cnt < 255) model_err_cnt++;
              check_eq("err_cnt", int'(err_cnt), model_err_cnt);
            end
            if (frame_ok) check_eq("valid_with_ok", int'(m_valid), 1);
            if (frame_err) check_eq("valid_with_err", int'(m_valid), 0);
            $display("event: got %0d expected %0d err_cnt=%0d", got_kind, k, err_cnt);
          end
        end

        case (ready_mode)
          0:       m_ready = 1'b1;
          1:       m_ready = 1'($urandom_range(0, 1));
          default: m_ready = ~m_ready;
        endcase
        rx_avail = (fifo_q.size() != 0) && (gate_mode == 0 || $urandom_range(0, 3) != 0);

        if (m_valid) begin
          if (have_hold) begin
            check_eq("stall_data", int'(m_data), int'(hold_data));
            check_eq("stall_last", int'(m_last), int'(hold_last));
            have_hold = 1'b0;
          end
          if (m_ready) begin
            if (cur_pl.size() == 0) begin
              check_eq("extra_beat", int'(m_data) + 1000, 0);
            end else begin
              logic [7:0] e;
              e = cur_pl.pop_front();
              check_eq("beat_data", int'(m_data), int'(e));
              check_eq("beat_last", int'(m_last), int'(cur_pl.size() == 0));
              last_xfer = (cur_pl.size() == 0);
              $display("beat: data=%02h last=%0d expected %02h", m_data, m_last, e);
            end
          end else begin
            have_hold = 1'b1;
            hold_data = m_data;
            hold_last = m_last;
          end
        end
      end
    end
  end

  task automatic drain(input int budget);
    logic done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      done = (fifo_q.size() == 0) && (ev_kind.size() == 0) &&
             (cur_pl.size() == 0) && !m_valid && !rx_rd_en;
      if (done) break;
    end
    repeat (4) @(negedge clk);
    #1;
    check_eq("drain_done", int'(done), 1);
  endtask

  task automatic build_random();
    int units;
    stream_q.delete();
    units = $urandom_range(1, 4);
    for (int u = 0; u < units; u++) begin
      int t;
      t = $urandom_range(0, 9);
      if (t <= 1) begin
        logic [7:0] nb;
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h00;
        stream_q.push_back(nb);
      end else if (t == 2) begin
        stream_q.push_back(8'hA5);
        if ($urandom_range(0, 1) == 0) stream_q.push_back(8'h00);
        else stream_q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        int l;
        int sum;
        l = $urandom_range(1, MAX_LEN);
        sum = l;
        stream_q.push_back(8'hA5);
        stream_q.push_back(8'(l));
        for (int k = 0; k < l; k++) begin
          logic [7:0] pb;
          pb = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
          stream_q.push_back(pb);
          sum += int'(pb);
        end
        if (t == 3) stream_q.push_back(8'(sum + $urandom_range(1, 255)));
        else stream_q.push_back(8'(sum));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rd_en", int'(rx_rd_en), 0);
    check_eq("rst_m_valid", int'(m_valid), 0);
    check_eq("rst_m_data", int'(m_data), 0);
    check_eq("rst_m_last", int'(m_last), 0);
    check_eq("rst_frame_ok", int'(frame_ok), 0);
    check_eq("rst_frame_err", int'(frame_err), 0);
    check_eq("rst_err_code", int'(err_code), 0);
    check_eq("rst_err_cnt", int'(err_cnt), 0);
    rst = 1'b0;

    // Basic frame.
    ready_mode = 0; gate_mode = 0;
    stream_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h35};
    model_and_send();
    drain(200);
    check_eq("basic_err_cnt", int'(err_cnt), 0);

    // Noise then a one-byte frame.
    stream_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    model_and_send();
    drain(200);
    check_eq("noise_err_cnt", int'(err_cnt), 0);

    // Zero and over-long lengths.
    stream_q = '{8'hA5, 8'h00, 8'hA5, 8'(MAX_LEN + 1)};
    model_and_send();
    drain(200);
    check_eq("badlen_err_cnt", int'(err_cnt), 2);
    check_eq("badlen_err_code", int'(err_code), 1);

    // Bad checksum followed by a good frame.
    stream_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h36, 8'hA5, 8'h02, 8'h11, 8'h22, 8'h35};
    model_and_send();
    drain(200);
    check_eq("csum_err_code", int'(err_code), 2);

    // Consumer stalls every other cycle.
    ready_mode = 2;
    stream_q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    model_and_send();
    drain(200);

    // Randomized streams.
    for (int r = 0; r < 40; r++) begin
      ready_mode = $urandom_range(0, 2);
      gate_mode  = $urandom_range(0, 1);
      build_random();
      model_and_send();
      drain(2000);
    end

    // Reset in the middle of a payload: no pulse, everything back to zero.
    ready_mode = 0; gate_mode = 0;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h05);
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h02);
    repeat (30) @(negedge clk);
    #1;
    rst = 1'b1;
    fifo_q.delete();
    #1;
    check_eq("midrst_rd_en", int'(rx_rd_en), 0);
    check_eq("midrst_m_valid", int'(m_valid), 0);
    check_eq("midrst_frame_err", int'(frame_err), 0);
    check_eq("midrst_err_code", int'(err_code), 0);
    check_eq("midrst_err_cnt", int'(err_cnt), 0);
    model_err_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stream_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h35};
    model_and_send();
    drain(200);

`ifdef UART_PARSER_TIMEOUT_EN
    // Frame stalls after one payload byte.
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h11);
    ev_kind.push_back(3);
    drain(TIMEOUT + 200);
    check_eq("timeout_err_code", int'(err_code), 3);
`endif

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
